// File: rtl/move_fetch_pkg.sv
// Shared definitions for the move-list fetch path: list geometry, entry flag
// offsets (relative to EVAL_WIDTH) and the fetch FSM state encoding.
package move_fetch_pkg;

   localparam int MAX_POSITIONS          = 256;
   localparam int DEF_MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS);
   localparam int DEF_EVAL_WIDTH         = 16;
   localparam int DEF_RAM_WIDTH          = DEF_EVAL_WIDTH + 8;

   // Flag bits sit directly above the signed eval field; move_sort uses the same layout.
   localparam int OFS_PV          = 3;
   localparam int OFS_CAPTURE     = 2;
   localparam int OFS_WHITE_CHECK = 1;
   localparam int OFS_BLACK_CHECK = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SORT,
      ST_CLEAR,
      ST_SETTLE,
      ST_READ,
      ST_PRESENT,
      ST_FINISH
   } fetch_state_t;

   function automatic int flag_bit(input int eval_width, input int ofs);
      return eval_width + ofs;
   endfunction

endpackage

// File: rtl/move_fetch_lat.sv
// Loadable down-counter used for both the post-clear settle delay and the
// port-B read latency wait; saturates at zero.
module move_fetch_lat #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   input  logic         i_dec,
   output logic         o_zero,
   output logic         o_one
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);
   assign o_one  = (r_cnt <= W'(1));

endmodule

// File: rtl/move_fetch.sv
// Reads the sorted move list out of move_sort port B and hands it out one
// entry per valid/ready handshake. MOVE_FETCH_SKIP_ILLEGAL_EN drops entries
// that leave the side to move in check and adds the skip_count output.
module move_fetch
   import move_fetch_pkg::*;
#(
   parameter int RAM_WIDTH          = DEF_RAM_WIDTH,
   parameter int EVAL_WIDTH         = DEF_EVAL_WIDTH,
   parameter int MAX_POSITIONS_LOG2 = DEF_MAX_POSITIONS_LOG2,
   parameter int RD_LATENCY         = 2,
   parameter int SETTLE_CYCLES      = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          fetch_start,
   input  logic                          fetch_abort,
   input  logic                          white_to_move,
   input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
   input  logic                          sort_complete,
   output logic                          sort_clear,
   output logic [MAX_POSITIONS_LOG2-1:0] ram_rd_addr,
   input  logic [RAM_WIDTH-1:0]          ram_rd_data,
   output logic                          move_valid,
   input  logic                          move_ready,
   output logic [RAM_WIDTH-1:0]          move_data,
   output logic [MAX_POSITIONS_LOG2-1:0] move_index,
   output logic                          move_last,
   output logic                          fetch_busy,
   output logic                          fetch_done
`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
   ,output logic [MAX_POSITIONS_LOG2-1:0] skip_count
`endif
);

   localparam int AW      = MAX_POSITIONS_LOG2;
   localparam int LAT_MAX = (SETTLE_CYCLES > RD_LATENCY) ? SETTLE_CYCLES : RD_LATENCY;
   localparam int LAT_W   = $clog2(LAT_MAX + 1);
   localparam logic [LAT_W-1:0] SETTLE_LD = LAT_W'(SETTLE_CYCLES);
   localparam logic [LAT_W-1:0] RD_LD     = LAT_W'(RD_LATENCY);

   fetch_state_t         r_state;
   logic                 r_start_d;
   logic                 r_abort_pend;
   logic [AW-1:0]        r_cnt;
   logic [AW-1:0]        r_idx;
   logic                 r_sort_clear;
   logic [AW-1:0]        r_ram_rd_addr;
   logic                 r_move_valid;
   logic [RAM_WIDTH-1:0] r_move_data;
   logic [AW-1:0]        r_move_index;
   logic                 r_move_last;
   logic                 r_busy;
   logic                 r_fetch_done;

   logic                 w_start_rise;
   logic                 w_idx_last;
   logic                 w_hs;
   logic [AW-1:0]        w_nxt_idx;
   logic                 w_lat_load;
   logic [LAT_W-1:0]     w_lat_val;
   logic                 w_lat_dec;
   logic                 w_lat_zero;
   logic                 w_lat_one;

`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
   localparam int WCHK = EVAL_WIDTH + OFS_WHITE_CHECK;
   localparam int BCHK = EVAL_WIDTH + OFS_BLACK_CHECK;
   logic [AW-1:0]        r_skip;
   logic                 r_pend_vld;
   logic [RAM_WIDTH-1:0] r_pend_data;
   logic [AW-1:0]        r_pend_idx;
   logic                 w_illegal;

   assign w_illegal  = white_to_move ? ram_rd_data[WCHK] : ram_rd_data[BCHK];
   assign skip_count = r_skip;
`else
   logic w_unused_wtm;
   assign w_unused_wtm = white_to_move;
`endif

   assign w_start_rise = fetch_start & ~r_start_d;
   // r_cnt is non-zero whenever this matters, so cnt-1 never wraps
   assign w_idx_last   = (r_cnt != '0) && (r_idx == r_cnt - 1'b1);
   assign w_hs         = r_move_valid & move_ready;
   assign w_nxt_idx    = r_idx + 1'b1;
   assign w_lat_dec    = (r_state == ST_SETTLE) || (r_state == ST_READ);

   always_comb begin
      w_lat_load = 1'b0;
      w_lat_val  = RD_LD;
      case (r_state)
         ST_CLEAR: begin
            w_lat_load = 1'b1;
            w_lat_val  = SETTLE_LD;
         end
         ST_SETTLE:  w_lat_load = w_lat_one;
         ST_READ:    w_lat_load = w_lat_zero;
         ST_PRESENT: w_lat_load = w_hs;
         default:    w_lat_load = 1'b0;
      endcase
   end

   move_fetch_lat #(.W(LAT_W)) u_lat (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_lat_load),
      .i_val   (w_lat_val),
      .i_dec   (w_lat_dec),
      .o_zero  (w_lat_zero),
      .o_one   (w_lat_one)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_start_d     <= 1'b0;
         r_abort_pend  <= 1'b0;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_sort_clear  <= 1'b0;
         r_ram_rd_addr <= '0;
         r_move_valid  <= 1'b0;
         r_move_data   <= '0;
         r_move_index  <= '0;
         r_move_last   <= 1'b0;
         r_busy        <= 1'b0;
         r_fetch_done  <= 1'b0;
`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
         r_skip        <= '0;
         r_pend_vld    <= 1'b0;
         r_pend_data   <= '0;
         r_pend_idx    <= '0;
`endif
      end else begin
         r_start_d    <= fetch_start;
         r_sort_clear <= 1'b0;
         r_fetch_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start_rise) begin
                  r_cnt        <= move_count;
                  r_busy       <= 1'b1;
                  r_abort_pend <= 1'b0;
                  r_state      <= ST_WAIT_SORT;
`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
                  r_skip       <= '0;
                  r_pend_vld   <= 1'b0;
`endif
               end
            end
            ST_WAIT_SORT: begin
               // an abort racing sort_complete still clears move_sort out of DONE
               if (sort_complete) begin
                  r_sort_clear <= 1'b1;
                  r_abort_pend <= fetch_abort;
                  r_state      <= ST_CLEAR;
               end else if (fetch_abort) begin
                  r_fetch_done <= 1'b1;
                  r_state      <= ST_FINISH;
               end
            end
            ST_CLEAR: begin
               r_idx <= '0;
               if (r_abort_pend || fetch_abort) begin
                  r_fetch_done <= 1'b1;
                  r_state      <= ST_FINISH;
               end else begin
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (fetch_abort || (w_lat_one && (r_cnt == '0))) begin
                  r_fetch_done <= 1'b1;
                  r_state      <= ST_FINISH;
               end else if (w_lat_one) begin
                  r_ram_rd_addr <= r_idx;
                  r_state       <= ST_READ;
               end
            end
            ST_READ: begin
               if (fetch_abort) begin
                  r_fetch_done <= 1'b1;
                  r_state      <= ST_FINISH;
               end else if (w_lat_zero) begin
`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
                  // one legal entry is held back until the next legal one (or the end) is seen
                  if (w_illegal) begin
                     r_skip <= r_skip + 1'b1;
                     if (w_idx_last && r_pend_vld) begin
                        r_move_data  <= r_pend_data;
                        r_move_index <= r_pend_idx;
                        r_move_last  <= 1'b1;
                        r_move_valid <= 1'b1;
                        r_pend_vld   <= 1'b0;
                        r_state      <= ST_PRESENT;
                     end else if (w_idx_last) begin
                        r_fetch_done <= 1'b1;
                        r_state      <= ST_FINISH;
                     end else begin
                        r_idx         <= w_nxt_idx;
                        r_ram_rd_addr <= w_nxt_idx;
                     end
                  end else if (!r_pend_vld && w_idx_last) begin
                     r_move_data  <= ram_rd_data;
                     r_move_index <= r_idx;
                     r_move_last  <= 1'b1;
                     r_move_valid <= 1'b1;
                     r_state      <= ST_PRESENT;
                  end else if (!r_pend_vld) begin
                     r_pend_data   <= ram_rd_data;
                     r_pend_idx    <= r_idx;
                     r_pend_vld    <= 1'b1;
                     r_idx         <= w_nxt_idx;
                     r_ram_rd_addr <= w_nxt_idx;
                  end else begin
                     r_move_data  <= r_pend_data;
                     r_move_index <= r_pend_idx;
                     r_move_last  <= 1'b0;
                     r_move_valid <= 1'b1;
                     r_pend_data  <= ram_rd_data;
                     r_pend_idx   <= r_idx;
                     r_state      <= ST_PRESENT;
                  end
`else
                  r_move_data  <= ram_rd_data;
                  r_move_index <= r_idx;
                  r_move_last  <= w_idx_last;
                  r_move_valid <= 1'b1;
                  r_state      <= ST_PRESENT;
`endif
               end
            end
            ST_PRESENT: begin
               if (w_hs || fetch_abort) begin
                  r_move_valid <= 1'b0;
                  if (r_move_last || fetch_abort) begin
                     r_fetch_done <= 1'b1;
                     r_state      <= ST_FINISH;
                  end
`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
                  else if (w_idx_last) begin
                     r_move_data  <= r_pend_data;
                     r_move_index <= r_pend_idx;
                     r_move_last  <= 1'b1;
                     r_pend_vld   <= 1'b0;
                  end
`endif
                  else begin
                     r_idx         <= w_nxt_idx;
                     r_ram_rd_addr <= w_nxt_idx;
                     r_state       <= ST_READ;
                  end
               end
`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
               else if (!r_move_valid) begin
                  r_move_valid <= 1'b1;
               end
`endif
            end
            ST_FINISH: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign sort_clear  = r_sort_clear;
   assign ram_rd_addr = r_ram_rd_addr;
   assign move_valid  = r_move_valid;
   assign move_data   = r_move_data;
   assign move_index  = r_move_index;
   assign move_last   = r_move_last;
   assign fetch_busy  = r_busy;
   assign fetch_done  = r_fetch_done;

endmodule

// File: tb/tb_move_fetch.sv
// Directed bench for move_fetch: a 2-cycle-latency RAM model behind port B and
// a scripted consumer that stalls, aborts and records every accepted move.
module tb_move_fetch;

   localparam int RW = 24;
   localparam int EW = 16;
   localparam int AW = 8;
   localparam int L  = 2;
   localparam int S  = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          fetch_start = 1'b0;
   logic          fetch_abort = 1'b0;
   logic          white_to_move = 1'b0;
   logic [AW-1:0] move_count = '0;
   logic          sort_complete = 1'b0;
   logic          move_ready = 1'b0;
   logic          sort_clear;
   logic [AW-1:0] ram_rd_addr;
   logic [RW-1:0] ram_rd_data;
   logic          move_valid;
   logic [RW-1:0] move_data;
   logic [AW-1:0] move_index;
   logic          move_last;
   logic          fetch_busy;
   logic          fetch_done;
`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
   logic [AW-1:0] skip_count;
`endif

   move_fetch #(
      .RAM_WIDTH(RW), .EVAL_WIDTH(EW), .MAX_POSITIONS_LOG2(AW),
      .RD_LATENCY(L), .SETTLE_CYCLES(S)
   ) dut (
      .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .fetch_abort(fetch_abort),
      .white_to_move(white_to_move), .move_count(move_count), .sort_complete(sort_complete),
      .sort_clear(sort_clear), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .move_valid(move_valid), .move_ready(move_ready), .move_data(move_data),
      .move_index(move_index), .move_last(move_last), .fetch_busy(fetch_busy),
      .fetch_done(fetch_done)
`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
      ,.skip_count(skip_count)
`endif
   );

   always #5 clk = ~clk;

   // port B model: data follows the address after exactly L clock edges
   logic [RW-1:0] mem [256];
   logic [AW-1:0] a1, a2;
   always @(posedge clk) begin
      a1 <= ram_rd_addr;
      a2 <= a1;
   end
   assign ram_rd_data = mem[a2];

   int checks = 0;
   int errors = 0;

   int            n_acc, n_clear, n_done, sort_cyc, done_cyc, unstable;
   logic          vld_after_abort, busy_end;
   bit            timeout;
   logic [AW-1:0] acc_idx  [16];
   logic [RW-1:0] acc_data [16];
   logic          acc_last [16];
   logic [AW-1:0] skip_at_done;

   task automatic start_fetch(input logic [AW-1:0] cnt, input bit hold);
      @(negedge clk);
      move_count  = cnt;
      fetch_start = 1'b1;
      if (!hold) begin
         @(negedge clk);
         fetch_start = 1'b0;
      end
   endtask

   // Plays move_sort and the consumer for one fetch, recording what was seen.
   task automatic observe(input int max_cyc, input int sort_at, input int stall_idx,
                          input int stall_n, input int abort_idx);
      int stall_left = stall_n;
      bit aborted = 0, abort_prev = 0, prev_v = 0, prev_hs = 0;
      logic [RW-1:0] pd = '0;
      logic [AW-1:0] pi = '0;
      logic pl = 1'b0;
      n_acc = 0; n_clear = 0; n_done = 0; sort_cyc = -1; done_cyc = -1; unstable = 0;
      vld_after_abort = 1'b1; busy_end = 1'bx; timeout = 1; skip_at_done = 'x;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (sort_clear) begin n_clear++; sort_complete = 1'b0; end
         if (abort_prev) vld_after_abort = move_valid;
         abort_prev = 0;
         fetch_abort = 1'b0;
         if (move_valid && prev_v && !prev_hs &&
             (move_data !== pd || move_index !== pi || move_last !== pl)) unstable++;
         if (fetch_done) begin
            n_done++;
            done_cyc = c;
`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
            skip_at_done = skip_count;
`endif
         end
         if (n_done > 0 && c > done_cyc) begin
            busy_end = fetch_busy;
            timeout  = 0;
            break;
         end
         if (c == sort_at) begin sort_complete = 1'b1; sort_cyc = c; end
         move_ready = 1'b1;
         if (move_valid && int'(move_index) == stall_idx && stall_left > 0) begin
            move_ready = 1'b0;
            stall_left--;
         end
         if (move_valid && int'(move_index) == abort_idx && !aborted) begin
            fetch_abort = 1'b1;
            move_ready  = 1'b0;
            aborted     = 1;
            abort_prev  = 1;
         end
         prev_hs = move_valid && move_ready;
         if (prev_hs && n_acc < 16) begin
            acc_idx[n_acc]  = move_index;
            acc_data[n_acc] = move_data;
            acc_last[n_acc] = move_last;
            n_acc++;
         end
         prev_v = move_valid; pd = move_data; pi = move_index; pl = move_last;
      end
      move_ready = 1'b0; fetch_abort = 1'b0; sort_complete = 1'b0;
   endtask

   task automatic test_reset();
      int bad = 0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({sort_clear, move_valid, move_last, fetch_busy, fetch_done, ram_rd_addr, move_index, move_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0",
                  {sort_clear, move_valid, move_last, fetch_busy, fetch_done, ram_rd_addr, move_index, move_data});
      end
      reset_n = 1'b1;
      @(negedge clk); fetch_abort = 1'b1;
      @(negedge clk); fetch_abort = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (fetch_busy !== 1'b0 || fetch_done !== 1'b0 || sort_clear !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL idle_abort_ignored: %0d active cycles, required 0", bad); end
   endtask

   task automatic test_basic();
      start_fetch(5, 0);
      observe(300, 20, -1, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL basic_timeout: no fetch_done"); end
      checks++; if (n_clear != 1) begin errors++; $display("FAIL basic_sort_clear: got %0d pulses required 1", n_clear); end
      checks++; if (n_acc != 5) begin errors++; $display("FAIL basic_count: got %0d moves required 5", n_acc); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (acc_idx[i] !== AW'(i) || acc_data[i] !== mem[i] || acc_last[i] !== (i == 4)) begin
            errors++;
            $display("FAIL basic_move%0d: got idx %0d data %h last %b required idx %0d data %h last %b",
                     i, acc_idx[i], acc_data[i], acc_last[i], i, mem[i], (i == 4));
         end
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL basic_done: got %0d pulses required 1", n_done); end
      checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b required 0", busy_end); end
   endtask

   task automatic test_zero_count();
      int bad = 0;
      start_fetch(0, 1);
      observe(100, 3, -1, 0, -1);
      checks++; if (n_clear != 1) begin errors++; $display("FAIL zero_sort_clear: got %0d required 1", n_clear); end
      checks++; if (n_acc != 0) begin errors++; $display("FAIL zero_moves: got %0d required 0", n_acc); end
      checks++;
      if (done_cyc - sort_cyc != 2 + S) begin
         errors++; $display("FAIL zero_done_latency: got %0d required %0d", done_cyc - sort_cyc, 2 + S);
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL zero_done: got %0d required 1", n_done); end
      repeat (10) begin
         @(negedge clk);
         if (fetch_busy !== 1'b0) bad++;
      end
      fetch_start = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL held_start_restart: busy %0d cycles required 0", bad); end
   endtask

   task automatic test_stall();
      start_fetch(3, 0);
      observe(300, 2, 1, 7, -1);
      checks++; if (n_acc != 3) begin errors++; $display("FAIL stall_count: got %0d required 3", n_acc); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (acc_idx[i] !== AW'(i) || acc_data[i] !== mem[i]) begin
            errors++;
            $display("FAIL stall_move%0d: got idx %0d data %h required idx %0d data %h", i, acc_idx[i], acc_data[i], i, mem[i]);
         end
      end
      checks++; if (unstable != 0) begin errors++; $display("FAIL stall_stable: %0d changes required 0", unstable); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL stall_done: got %0d required 1", n_done); end
   endtask

   task automatic test_abort();
      start_fetch(6, 0);
      observe(300, 2, -1, 0, 2);
      checks++;
      if (n_acc != 2 || acc_idx[0] !== 8'd0 || acc_idx[1] !== 8'd1) begin
         errors++; $display("FAIL abort_moves: got %0d moves required 2 (idx 0,1)", n_acc);
      end
      checks++; if (vld_after_abort !== 1'b0) begin errors++; $display("FAIL abort_valid_drop: got %b required 0", vld_after_abort); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL abort_done: got %0d required 1", n_done); end
      checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL abort_busy_end: got %b required 0", busy_end); end
   endtask

   task automatic test_restart();
      start_fetch(2, 0);
      observe(300, 2, -1, 0, -1);
      checks++;
      if (n_acc != 2 || acc_idx[0] !== 8'd0 || acc_idx[1] !== 8'd1 || acc_data[1] !== mem[1]) begin
         errors++; $display("FAIL restart_moves: got %0d moves required 2", n_acc);
      end
      checks++;
      if (acc_last[0] !== 1'b0 || acc_last[1] !== 1'b1) begin
         errors++; $display("FAIL restart_last: got %b%b required 01", acc_last[0], acc_last[1]);
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL restart_done: got %0d required 1", n_done); end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      int bad = 0;
      start_fetch(3, 0);
      sort_complete = 1'b1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (sort_clear) seen = 1;
      end
      sort_complete = 1'b0;
      checks++; if (!seen) begin errors++; $display("FAIL rmid_sort_clear: got none required 1"); end
      repeat (4) @(negedge clk);
      checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b required 1", fetch_busy); end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({sort_clear, move_valid, move_last, fetch_busy, fetch_done, ram_rd_addr, move_index, move_data} !== '0) begin
         errors++;
         $display("FAIL rmid_async_clear: got %h required 0",
                  {sort_clear, move_valid, move_last, fetch_busy, fetch_done, ram_rd_addr, move_index, move_data});
      end
      repeat (4) begin
         @(negedge clk);
         if (sort_clear !== 1'b0) bad++;
      end
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (sort_clear !== 1'b0 || fetch_busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rmid_quiet: %0d bad cycles required 0", bad); end
   endtask

`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
   task automatic test_skip();
      logic [RW-1:0] chk;
      chk = '0;
      chk[EW+1] = 1'b1;
      mem[1] = mem[1] | chk;
      mem[3] = mem[3] | chk;
      white_to_move = 1'b1;
      start_fetch(4, 0);
      observe(300, 2, -1, 0, -1);
      checks++;
      if (n_acc != 2 || acc_idx[0] !== 8'd0 || acc_idx[1] !== 8'd2 || acc_data[1] !== mem[2]) begin
         errors++; $display("FAIL skip_moves: got %0d moves idx %0d,%0d required 0,2", n_acc, acc_idx[0], acc_idx[1]);
      end
      checks++;
      if (acc_last[0] !== 1'b0 || acc_last[1] !== 1'b1) begin
         errors++; $display("FAIL skip_last: got %b%b required 01", acc_last[0], acc_last[1]);
      end
      checks++; if (skip_at_done !== 8'd2) begin errors++; $display("FAIL skip_count: got %0d required 2", skip_at_done); end
      mem[1] = mem[1] & ~chk;
      mem[3] = mem[3] & ~chk;
      white_to_move = 1'b0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8'h08, 16'(16'h0102 + i * 16'h1111)};
      test_reset();
      test_basic();
      test_zero_count();
      test_stall();
      test_abort();
      test_restart();
      test_reset_mid();
`ifdef MOVE_FETCH_SKIP_ILLEGAL_EN
      test_skip();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/move_fetch.md
Name: move_fetch

Overview:
- Consumer end of the move_sort RAM: waits for `sort_complete`, releases the sorter with `sort_clear`, then reads the sorted move list out of port B.
- Presents moves one per valid/ready handshake, best-first, to the search controller.
- Sits between move_sort and the search/evaluation sequencer; owns `ram_rd_addr` and `sort_clear` exclusively.

Parameters:
- RAM_WIDTH, 0, width of one move-list entry (eval in [EVAL_WIDTH-1:0], flags above it).
- EVAL_WIDTH, 0, width of the signed static-eval field.
- MAX_POSITIONS_LOG2, $clog2(`MAX_POSITIONS), width of address and count.
- RD_LATENCY, 2, cycles from `ram_rd_addr` change to valid `ram_rd_data`; legal range 1..3.
- SETTLE_CYCLES, 2, cycles after the `sort_clear` pulse before the first read address is driven.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- fetch_start  in  1  rising-edge start request
- fetch_abort  in  1  level; abandon current fetch
- white_to_move  in  1  side to move (used only with the optional feature)
- move_count  in  MAX_POSITIONS_LOG2  entries written; sampled at start
- sort_complete  in  1  from move_sort
- sort_clear  out  1  one-cycle pulse to move_sort
- ram_rd_addr  out  MAX_POSITIONS_LOG2  port B read address
- ram_rd_data  in  RAM_WIDTH  port B read data
- move_valid  out  1  move_data valid
- move_ready  in  1  consumer accepts
- move_data  out  RAM_WIDTH  current entry
- move_index  out  MAX_POSITIONS_LOG2  RAM index of move_data
- move_last  out  1  qualifies the final move
- fetch_busy  out  1  high from start until return to IDLE
- fetch_done  out  1  one-cycle pulse at list exhaustion or abort

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset is asynchronous assert, synchronous deassert via the usual 2-flop synchroniser upstream.
- IDLE:
  - Registers a delayed copy of `fetch_start`.
  - On a rising edge: latch `cnt <= move_count`, set `fetch_busy`, go to WAIT_SORT.
  - A held-high `fetch_start` does not restart.
- WAIT_SORT: on `sort_complete` go to CLEAR, else stay. No timeout.
- CLEAR:
  - `sort_clear = 1` for exactly one cycle. move_sort needs this to leave DONE and re-enable external port B access.
  - `idx <= 0`, settle counter `<= SETTLE_CYCLES`.
  - Go to SETTLE.
- SETTLE: count down. At 0: if `cnt == 0` go to FINISH; else drive `ram_rd_addr = idx` and go to READ.
- READ:
  - Hold `ram_rd_addr` for RD_LATENCY cycles via a latency counter.
  - Then register `move_data <= ram_rd_data`, `move_index <= idx`, `move_last <= (idx == cnt-1)`, and go to PRESENT.
- PRESENT:
  - `move_valid = 1`; `move_data`, `move_index` and `move_last` stay stable until the handshake.
  - On `move_valid & move_ready`: drop `move_valid` the next cycle. If `move_last`, go to FINISH; else `idx <= idx+1` and go to READ.
  - There is no back-to-back throughput requirement: at most one move per RD_LATENCY+2 cycles.
- FINISH: pulse `fetch_done` for 1 cycle, clear `fetch_busy`, go to IDLE.
- Abort:
  - `fetch_abort` in WAIT_SORT/SETTLE/READ/PRESENT: `move_valid` falls the next cycle and the state goes to FINISH.
  - If abort arrives in WAIT_SORT while `sort_complete = 1`, go through CLEAR first so move_sort is never left stuck in DONE.
  - Abort in IDLE is ignored.
- Simultaneous events:
  - Handshake and abort in the same cycle: the handshake counts, then FINISH.
  - `fetch_start` while busy is ignored.
- Widths and arithmetic:
  - Compute `cnt-1` only when `cnt != 0`; no wrap.
  - `idx` never exceeds `cnt-1`. `cnt == 2**MAX_POSITIONS_LOG2 - 1` works without overflow.
- Reset mid-operation: immediate IDLE. `sort_clear` is not issued. The system reset also clears move_sort.

Optional Feature:
- Macro: MOVE_FETCH_SKIP_ILLEGAL_EN.
- Defined:
  - In READ, after data capture, the entry is skipped when the side-to-move king is in check: `white_to_move & ram_rd_data[EVAL_WIDTH+1]`, or `~white_to_move & ram_rd_data[EVAL_WIDTH]`.
  - A skipped entry is never presented.
  - `move_last` asserts on the last non-skipped entry, so the block must look ahead one entry; it stays in PRESENT with `move_last = 0` until the next legal entry or the end is found.
  - All entries skipped: zero moves presented, then `fetch_done`.
  - Extra output `skip_count[MAX_POSITIONS_LOG2-1:0]`, valid while `fetch_done` is high.
- Undefined: every entry is presented and no `skip_count` port exists.

Decomposition:
- Shared package (vchess.vh / vchess_pkg): state encoding constants, entry-field bit offsets (PV = EVAL_WIDTH+3, CAPTURE = +2, WHITE_CHECK = +1, BLACK_CHECK = +0), MAX_POSITIONS.
- move_sort uses the same offsets.
- One sub-module: move_fetch_lat, a loadable down-counter shared by SETTLE and READ.

Test Plan:
- `move_count = 5`, RAM holds 5 distinct entries, `sort_complete` at cycle 20, `move_ready` always 1 -> one `sort_clear` pulse; indices 0..4 presented in order, data matches RAM; `move_last` only on index 4; `fetch_done` once.
- `move_count = 0` -> `sort_clear` pulse, no `move_valid`, `fetch_done` 2+SETTLE_CYCLES cycles after `sort_complete`.
- `move_count = 3`, `move_ready` low for 7 cycles on index 1 -> `move_data` and `move_index` stable throughout; no duplicated or missing index.
- `fetch_abort` during PRESENT of index 2 of 6 -> `move_valid` low next cycle, `fetch_done` pulse, IDLE; a new `fetch_start` works.
- `reset_n` low mid-READ -> all outputs 0 asynchronously, `sort_clear` never asserted.
- With MOVE_FETCH_SKIP_ILLEGAL_EN defined, `white_to_move = 1`, 4 entries with entries 1 and 3 having WHITE_CHECK set -> only 0 and 2 presented, `move_last` on 2, `skip_count = 2`.
